// File: rtl/pwm_duty_decoder_if.sv
// Measurement bus of the PWM duty decoder: PWM input plus the measured period, high time and status.
// The decoder sits on the master side; whoever consumes the measurement uses the slave side.
interface pwm_duty_decoder_if #(
    parameter int CNT_W = 16
);
    logic             pwm_in;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] high_cnt;
    logic [3:0]       duty_tenths;
    logic             meas_valid;
    logic             stuck_high;
    logic             stuck_low;
    logic             overrun;

    modport master (
        input  pwm_in,
        output period_cnt,
        output high_cnt,
        output duty_tenths,
        output meas_valid,
        output stuck_high,
        output stuck_low,
        output overrun
    );

    modport slave (
        output pwm_in,
        input  period_cnt,
        input  high_cnt,
        input  duty_tenths,
        input  meas_valid,
        input  stuck_high,
        input  stuck_low,
        input  overrun
    );
endinterface

// File: rtl/pwm_duty_decoder.sv
// Measures period and high time of an incoming PWM signal and converts them to duty in 10% steps.
// Optional glitch filter on the synchronized input is enabled by defining PWM_DECODER_GLITCH_FILTER_EN.
module pwm_duty_decoder #(
    parameter int CNT_W    = 16,
    parameter int TIMEOUT  = 1000,
    parameter int FILT_LEN = 3
) (
    input logic              clk,
    input logic              rst,
    pwm_duty_decoder_if.master bus
);
    localparam int NUM_W  = CNT_W + 4;
    localparam int ITER_W = $clog2(NUM_W);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    if (FILT_LEN < 2 || FILT_LEN > 15) begin : g_filt_len_check
        $error("pwm_duty_decoder: FILT_LEN must be in 2..15");
    end
    if (TIMEOUT >= (2 ** CNT_W) - 1) begin : g_timeout_check
        $error("pwm_duty_decoder: TIMEOUT must be below 2**CNT_W - 1");
    end

    logic             sync_a;
    logic             sync_b;
    logic             s;
    logic             s_prev;
    logic             rise;
    logic             fall;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] h_lat;

    logic             div_busy;
    logic [ITER_W-1:0] div_iter;
    logic [NUM_W-1:0] div_num;
    logic [CNT_W-1:0] div_den;
    logic [CNT_W-1:0] div_h;
    logic [CNT_W-1:0] div_rem;
    logic [NUM_W-2:0] div_q;

    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] high_q;
    logic [3:0]       duty_q;
    logic             meas_valid_q;
    logic             stuck_high_q;
    logic             stuck_low_q;
    logic             overrun_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            s_prev <= 1'b0;
        end else begin
            sync_a <= bus.pwm_in;
            sync_b <= sync_a;
            s_prev <= s;
        end
    end

`ifdef PWM_DECODER_GLITCH_FILTER_EN
    logic       filt_q;
    logic [3:0] filt_cnt;

    // Output follows the synchronized input only after FILT_LEN identical samples in a row.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q   <= 1'b0;
            filt_cnt <= 4'd0;
        end else if (sync_b == filt_q) begin
            filt_cnt <= 4'd0;
        end else if (filt_cnt == 4'(FILT_LEN - 1)) begin
            filt_q   <= sync_b;
            filt_cnt <= 4'd0;
        end else begin
            filt_cnt <= filt_cnt + 4'd1;
        end
    end

    assign s = filt_q;
`else
    assign s = sync_b;
`endif

    assign rise = s & ~s_prev;
    assign fall = ~s & s_prev;

    logic             cnt_sat;
    logic             run_sat;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] run_inc;
    logic             meas_stuck;
    logic             idle_stuck;
    logic             stuck_evt;
    logic             launch;
    logic             div_last;
    logic             div_free;
    logic [NUM_W-1:0] num_load;

    assign cnt_sat = (cnt == TIMEOUT_C);
    assign run_sat = (run_cnt == TIMEOUT_C);
    assign cnt_inc = cnt_sat ? cnt : cnt + CNT_W'(1);
    assign run_inc = run_sat ? run_cnt : run_cnt + CNT_W'(1);

    // A rise always wins over a timeout in the same cycle; the idle detector fires once per stuck level.
    assign meas_stuck = (state != IDLE) && cnt_sat && !rise;
    assign idle_stuck = (state == IDLE) && run_sat && !rise && (s ? !stuck_high_q : !stuck_low_q);
    assign stuck_evt  = meas_stuck || idle_stuck;

    assign launch   = (state == LOW) && rise;
    assign div_last = div_busy && (div_iter == ITER_W'(NUM_W - 1));
    assign div_free = !div_busy || div_last;

    assign num_load = ({4'b0000, h_lat} << 3) + ({4'b0000, h_lat} << 1) + NUM_W'(cnt >> 1);

    logic [CNT_W:0]   rem_sh;
    logic [CNT_W:0]   rem_diff;
    logic             div_ge;
    logic [CNT_W-1:0] rem_next;
    logic [NUM_W-1:0] q_next;
    logic [3:0]       duty_next;

    // One restoring-division step; the borrow of the trial subtraction decides the quotient bit.
    always_comb begin
        rem_sh    = {div_rem, div_num[NUM_W-1]};
        rem_diff  = rem_sh - {1'b0, div_den};
        div_ge    = ~rem_diff[CNT_W];
        rem_next  = div_ge ? rem_diff[CNT_W-1:0] : rem_sh[CNT_W-1:0];
        q_next    = {div_q, div_ge};
        duty_next = (q_next > NUM_W'(10)) ? 4'd10 : q_next[3:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            run_cnt      <= '0;
            h_lat        <= '0;
            div_busy     <= 1'b0;
            div_iter     <= '0;
            div_num      <= '0;
            div_den      <= '0;
            div_h        <= '0;
            div_rem      <= '0;
            div_q        <= '0;
            period_q     <= '0;
            high_q       <= '0;
            duty_q       <= 4'd0;
            meas_valid_q <= 1'b0;
            stuck_high_q <= 1'b0;
            stuck_low_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            meas_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            run_cnt      <= (rise || fall) ? '0 : run_inc;

            case (state)
                IDLE: begin
                    if (rise) begin
                        state <= HIGH;
                        cnt   <= CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (meas_stuck) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (fall) begin
                        h_lat <= cnt;
                        state <= LOW;
                        cnt   <= cnt_inc;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                LOW: begin
                    if (rise) begin
                        state <= HIGH;
                        cnt   <= CNT_W'(1);
                    end else if (meas_stuck) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase

            if (rise) begin
                stuck_high_q <= 1'b0;
                stuck_low_q  <= 1'b0;
            end else if (stuck_evt) begin
                stuck_high_q <= s;
                stuck_low_q  <= ~s;
            end

            if (stuck_evt) begin
                period_q     <= '0;
                high_q       <= '0;
                duty_q       <= s ? 4'd10 : 4'd0;
                meas_valid_q <= 1'b1;
            end else if (div_last) begin
                period_q     <= div_den;
                high_q       <= div_h;
                duty_q       <= duty_next;
                meas_valid_q <= 1'b1;
            end

            if (div_busy) begin
                div_num <= {div_num[NUM_W-2:0], 1'b0};
                div_rem <= rem_next;
                div_q   <= q_next[NUM_W-2:0];
                if (div_last) begin
                    div_busy <= 1'b0;
                end else begin
                    div_iter <= div_iter + ITER_W'(1);
                end
            end

            // A launch in the divider's final cycle is accepted and overrides the wrap-up above.
            if (launch) begin
                if (div_free) begin
                    div_busy <= 1'b1;
                    div_iter <= '0;
                    div_num  <= num_load;
                    div_den  <= cnt;
                    div_h    <= h_lat;
                    div_rem  <= '0;
                    div_q    <= '0;
                end else begin
                    overrun_q <= 1'b1;
                end
            end
        end
    end

    assign bus.period_cnt  = period_q;
    assign bus.high_cnt    = high_q;
    assign bus.duty_tenths = duty_q;
    assign bus.meas_valid  = meas_valid_q;
    assign bus.stuck_high  = stuck_high_q;
    assign bus.stuck_low   = stuck_low_q;
    assign bus.overrun     = overrun_q;
endmodule

// File: doc/pwm_duty_decoder.md
Name: pwm_duty_decoder

Overview:
- Receive-side counterpart of the PWM generator: samples an incoming PWM waveform on the system clock and measures its period and high time in clock cycles.
- Converts each measurement to a duty value in 10% steps (0..10), the same encoding the generator uses.
- Used for loopback self-test of the generator output and for reading externally supplied PWM.
- Flags stuck-high and stuck-low inputs as 100% and 0% duty.

Parameters:
- CNT_W, 16: width of the period and high-time counters and their outputs.
- TIMEOUT, 1000: number of cycles without an edge before the input is declared stuck. Must be less than 2^CNT_W − 1.
- FILT_LEN, 3: number of stable samples required by the optional glitch filter, range 2..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- pwm_in  in  1  asynchronous PWM input.
- period_cnt  out  CNT_W  cycles between the last two accepted rising edges.
- high_cnt  out  CNT_W  cycles from the last accepted rising edge to its falling edge.
- duty_tenths  out  4  duty in 10% steps, 0..10.
- meas_valid  out  1  one-cycle pulse when the outputs update.
- stuck_high  out  1  input has been high for at least TIMEOUT cycles.
- stuck_low  out  1  input has been low for at least TIMEOUT cycles.
- overrun  out  1  one-cycle pulse when a completed period is dropped because the divider is busy.

Behaviour:
- Reset: all outputs, counters, synchronizer flops and the FSM are cleared to 0; FSM enters IDLE. A reset mid-measurement or mid-division discards all partial results; no meas_valid is issued.
- Input path:
  - 2-flop synchronizer, then a registered copy s_prev.
  - rise = s & ~s_prev; fall = ~s & s_prev.
  - All counts are taken in the synchronized domain.
- Measurement FSM, states IDLE, HIGH, LOW:
  - IDLE: wait for rise → HIGH, with cnt = 1.
  - HIGH: cnt increments each cycle. On fall: latch h = cnt → LOW.
  - LOW: cnt increments each cycle. On rise: latch p = cnt, launch the divider with (h, p), set cnt = 1 → HIGH.
- cnt saturates at TIMEOUT; it never wraps.
- Stuck detection:
  - In HIGH or LOW, cnt reaching TIMEOUT sets stuck_high (if s = 1) or stuck_low (if s = 0).
  - On that event: duty_tenths = 10 or 0 respectively, period_cnt = 0, high_cnt = 0, meas_valid pulses once, FSM → IDLE.
  - In IDLE, the same detection runs on a separate run-length counter. This reports a constant input after reset.
  - A stuck flag clears on the next rise.
- Divider:
  - Serial restoring division computing duty = floor((10*h + floor(p/2)) / p); the result is clamped to 10.
  - Takes exactly CNT_W+4 iterations, one per cycle, starting the cycle after launch.
  - In the cycle after the last iteration: period_cnt ← p, high_cnt ← h, duty_tenths ← quotient, meas_valid = 1.
  - Total latency from the rise that closes a period to meas_valid = CNT_W+5 cycles.
- Busy rule:
  - A launch while the divider is busy is dropped and overrun pulses.
  - Measurement continues unaffected.
  - The in-flight division completes normally.
- Simultaneous events:
  - Rise in the same cycle cnt reaches TIMEOUT: the rise wins, a normal period is recorded, no stuck flag is set.
  - Launch in the same cycle the divider finishes: accepted, no overrun.
- Outputs hold their last values between meas_valid pulses.

Optional Feature:
- Macro: PWM_DECODER_GLITCH_FILTER_EN
- Defined:
  - A filter between the synchronizer and edge detector changes its output only after the synchronized input has held the new level for FILT_LEN consecutive cycles.
  - Pulses shorter than FILT_LEN cycles are ignored.
  - Adds FILT_LEN cycles of latency to every edge; widths are preserved.
- Not defined: the filter is absent, and s is the synchronizer output directly.

Test Plan:
- Generator loopback at duty 5 (period 10, high 5) → period_cnt = 10, high_cnt = 5, duty_tenths = 5, no overrun when launches are ≥ 21 cycles apart (CNT_W = 16). With back-to-back 10-cycle periods, every other result is dropped and overrun pulses.
- Period 100, high 34 → duty_tenths = 3; high 35 → duty_tenths = 4 (rounding); high 99 → duty_tenths = 10.
- Hold pwm_in = 1 for 1500 cycles after one rise → stuck_high = 1, duty_tenths = 10, single meas_valid; the next rise clears stuck_high.
- Hold pwm_in = 0 from reset → stuck_low = 1 after TIMEOUT cycles plus synchronizer latency, duty_tenths = 0.
- Assert rst during the divide phase → all outputs 0, no meas_valid. The first result after release requires two rises.
- With the macro defined: a 2-cycle low glitch inside a 50-cycle high pulse (FILT_LEN = 3) → high_cnt = 50, no extra edge. Without the macro: high_cnt is measured to the glitch.
